cve2_instr_bus_arbiter: RTL and testbench

Two-requester arbiter that shares one OBI-style instruction memory port between the core fetch path (requester 0, driven by the prefetch buffer's `instr_req_o`/`instr_addr_o`) and a secondary fetch requester (requester 1, e.g. debug-module program buffer or boot-loader DMA). It adds no latency in either direction. It tracks outstanding transactions in an owner FIFO so that each response returns to the requester that issued it. It sits between the IF stage and the instruction bus, below `cve2_if_stage`.

---
 rtl/cve2_instr_bus_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_cve2_instr_bus_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cve2_instr_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cve2_instr_bus_arbiter
//
// Shares one OBI-style instruction memory port between two fetch requesters:
//   requester 0 : core fetch path (prefetch buffer)
//   requester 1 : secondary fetcher (debug program buffer, boot DMA, ...)
//
// Zero added latency in both directions. Request, grant and response paths are
// purely combinational. A small owner FIFO records which requester issued each
// granted transaction so that in-order responses are steered back correctly.
//
// Optional feature macro: CVE2_IBUS_ARB_RR_EN
//   defined   -> round-robin on contention (pointer toggles after each grant)
//   undefined -> fixed priority, requester 0 wins on contention
//
// Parameters:
//   MaxOutstanding  in-flight granted-but-unanswered transactions (1..4)
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   m0_req_i / m0_addr_i       requester 0 request and word address
//   m0_gnt_o                   requester 0 grant
//   m0_rvalid_o / m0_err_o     requester 0 response valid / bus error
//   m1_*                       same set for requester 1
//   rdata_o                    shared read data (from s_rdata_i)
//   s_req_o / s_addr_o         bus request and address
//   s_gnt_i                    bus grant
//   s_rvalid_i / s_rdata_i     bus response valid and read data
//   s_err_i                    bus error
//   busy_o                     outstanding transactions or pending requests
// -----------------------------------------------------------------------------
module cve2_instr_bus_arbiter #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic        m0_err_o,

    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic        m1_err_o,

    output logic [31:0] rdata_o,

    output logic        s_req_o,
    output logic [31:0] s_addr_o,
    input  logic        s_gnt_i,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i,
    input  logic        s_err_i,

    output logic        busy_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    // -------------------------------------------------------------------------
    // Requester vectors, so per-master logic can be generated
    // -------------------------------------------------------------------------
    logic [1:0]  req_vec;
    logic [31:0] addr_vec [2];
    logic [1:0]  gnt_vec;
    logic [1:0]  rvalid_vec;
    logic [1:0]  err_vec;

    assign req_vec     = {m1_req_i, m0_req_i};
    assign addr_vec[0] = m0_addr_i;
    assign addr_vec[1] = m1_addr_i;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [MaxOutstanding-1:0] fifo_mem_reg;
    logic [PtrW-1:0]           wr_ptr_reg, wr_ptr_next;
    logic [PtrW-1:0]           rd_ptr_reg, rd_ptr_next;
    logic [CntW-1:0]           count_reg, count_next;
    logic                      lock_valid_reg, lock_valid_next;
    logic                      lock_sel_reg, lock_sel_next;

    logic sel;
    logic prio_sel;
    logic free_slot;
    logic push;
    logic pop;
    logic empty;
    logic fifo_head;

    // -------------------------------------------------------------------------
    // Contention winner
    // -------------------------------------------------------------------------
`ifdef CVE2_IBUS_ARB_RR_EN
    // Points at the master that was NOT granted last; it wins the next tie.
    logic prio_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_reg <= 1'b0;
        end else if (push) begin
            prio_reg <= ~sel;
        end
    end

    assign prio_sel = prio_reg;
`else
    assign prio_sel = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Selection. A pending-but-ungranted request keeps its owner locked so the
    // address presented on the bus cannot change before the grant.
    // -------------------------------------------------------------------------
    always_comb begin
        sel = 1'b0;
        if (lock_valid_reg) begin
            sel = lock_sel_reg;
        end else if (req_vec == 2'b11) begin
            sel = prio_sel;
        end else if (req_vec[1]) begin
            sel = 1'b1;
        end
    end

    // A full FIFO may still accept a new entry when a response frees a slot in
    // the same cycle; count never exceeds MaxOutstanding, so != means <.
    assign free_slot = (count_reg != CntMax) | s_rvalid_i;

    assign s_req_o  = free_slot & req_vec[sel];
    assign s_addr_o = addr_vec[sel];

    always_comb begin
        lock_valid_next = lock_valid_reg;
        lock_sel_next   = lock_sel_reg;
        if (s_req_o) begin
            if (s_gnt_i) begin
                lock_valid_next = 1'b0;
            end else begin
                lock_valid_next = 1'b1;
                lock_sel_next   = sel;
            end
        end else if (lock_valid_reg && !req_vec[lock_sel_reg]) begin
            // Locked master withdrew its request: release so the other
            // master is not starved.
            lock_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_valid_reg <= 1'b0;
            lock_sel_reg   <= 1'b0;
        end else begin
            lock_valid_reg <= lock_valid_next;
            lock_sel_reg   <= lock_sel_next;
        end
    end

    // -------------------------------------------------------------------------
    // Owner FIFO
    // -------------------------------------------------------------------------
    assign empty     = (count_reg == '0);
    assign push      = s_req_o & s_gnt_i;
    // A response with nothing outstanding has no owner and is dropped.
    assign pop       = s_rvalid_i & ~empty;
    assign fifo_head = fifo_mem_reg[rd_ptr_reg];

    assign wr_ptr_next = !push ? wr_ptr_reg :
                         (wr_ptr_reg == PtrLast) ? '0 : wr_ptr_reg + PtrW'(1);
    assign rd_ptr_next = !pop ? rd_ptr_reg :
                         (rd_ptr_reg == PtrLast) ? '0 : rd_ptr_reg + PtrW'(1);

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CntW'(1);
            2'b01:   count_next = count_reg - CntW'(1);
            default: count_next = count_reg;
        endcase
    end

    // At full with a simultaneous pop, wr_ptr equals rd_ptr: the head is read
    // combinationally this cycle before the slot is overwritten at the edge.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_reg[wr_ptr_reg] <= sel;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // -------------------------------------------------------------------------
    // Per-master grant and response steering
    // -------------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        assign gnt_vec[gi]    = s_gnt_i & s_req_o & (sel == 1'(gi));
        assign rvalid_vec[gi] = s_rvalid_i & ~empty & (fifo_head == 1'(gi));
        assign err_vec[gi]    = s_err_i & rvalid_vec[gi];
    end

    assign m0_gnt_o    = gnt_vec[0];
    assign m1_gnt_o    = gnt_vec[1];
    assign m0_rvalid_o = rvalid_vec[0];
    assign m1_rvalid_o = rvalid_vec[1];
    assign m0_err_o    = err_vec[0];
    assign m1_err_o    = err_vec[1];

    assign rdata_o = s_rdata_i;
    assign busy_o  = (count_reg != '0) | m0_req_i | m1_req_i;

`ifndef SYNTHESIS
    // A response with no owner indicates a bus/arbiter reset mismatch.
    rvalid_has_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(s_rvalid_i && empty));
`endif

endmodule

// File: tb/tb_cve2_instr_bus_arbiter.sv
`timescale 1ns/1ps
// Testbench for cve2_instr_bus_arbiter: directed cycles with a response
// scoreboard holding the expected owner of each granted transaction.
module tb_cve2_instr_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] rdata;
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_gnt, s_rvalid, s_err;
    logic [31:0] s_rdata;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int owner_q[$];

    always #5 clk = ~clk;

    cve2_instr_bus_arbiter #(.MaxOutstanding(2)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .m0_req_i   (m0_req),
        .m0_addr_i  (m0_addr),
        .m0_gnt_o   (m0_gnt),
        .m0_rvalid_o(m0_rvalid),
        .m0_err_o   (m0_err),
        .m1_req_i   (m1_req),
        .m1_addr_i  (m1_addr),
        .m1_gnt_o   (m1_gnt),
        .m1_rvalid_o(m1_rvalid),
        .m1_err_o   (m1_err),
        .rdata_o    (rdata),
        .s_req_o    (s_req),
        .s_addr_o   (s_addr),
        .s_gnt_i    (s_gnt),
        .s_rvalid_i (s_rvalid),
        .s_rdata_i  (s_rdata),
        .s_err_i    (s_err),
        .busy_o     (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        m0_req = 1'b0; m0_addr = '0;
        m1_req = 1'b0; m1_addr = '0;
        s_gnt = 1'b0; s_rvalid = 1'b0; s_err = 1'b0; s_rdata = '0;
    endtask

    // One bus cycle. exp_sel: -1 = no bus request expected, else selected master.
    task automatic cyc(input logic r0, input logic [31:0] a0,
                       input logic r1, input logic [31:0] a1,
                       input logic gnt, input logic rv, input logic er,
                       input int exp_sel, input string tag);
        int         owner;
        logic       busy_exp;
        logic [1:0] onehot;
        @(posedge clk);
        #1;
        m0_req = r0; m0_addr = a0;
        m1_req = r1; m1_addr = a1;
        s_gnt = gnt; s_rvalid = rv; s_err = er;
        s_rdata = $urandom();
        @(negedge clk);
        busy_exp = (owner_q.size() != 0) || r0 || r1;
        check_val({tag, ".busy"}, 32'(busy), 32'(busy_exp));
        if (exp_sel < 0) begin
            check_val({tag, ".req"}, 32'(s_req), 32'd0);
            check_val({tag, ".gnt"}, 32'({m1_gnt, m0_gnt}), 32'd0);
        end else begin
            onehot = (exp_sel == 1) ? 2'b10 : 2'b01;
            check_val({tag, ".req"}, 32'(s_req), 32'd1);
            check_val({tag, ".addr"}, s_addr, (exp_sel == 1) ? a1 : a0);
            check_val({tag, ".gnt"}, 32'({m1_gnt, m0_gnt}), gnt ? 32'(onehot) : 32'd0);
        end
        if (rv) begin
            owner  = (owner_q.size() != 0) ? owner_q.pop_front() : -1;
            onehot = (owner == 1) ? 2'b10 : (owner == 0) ? 2'b01 : 2'b00;
            check_val({tag, ".rvalid"}, 32'({m1_rvalid, m0_rvalid}), 32'(onehot));
            check_val({tag, ".err"}, 32'({m1_err, m0_err}), er ? 32'(onehot) : 32'd0);
            check_val({tag, ".rdata"}, rdata, s_rdata);
            $display("[%0t] %s response owner=%0d err=%b", $time, tag, owner, er);
        end else begin
            check_val({tag, ".rvalid"}, 32'({m1_rvalid, m0_rvalid}), 32'd0);
        end
        if (exp_sel >= 0 && gnt) begin
            owner_q.push_back(exp_sel);
            $display("[%0t] %s grant m%0d addr=%h", $time, tag, exp_sel, s_addr);
        end
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        drive_idle();
        rst_n = 1'b0;
        #2;
        check_val({tag, ".outs"},
                  32'({s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, busy}), 32'd0);
        check_val({tag, ".addr"}, s_addr, 32'd0);
        check_val({tag, ".rdata"}, rdata, 32'd0);
        owner_q.delete();
        $display("[%0t] %s reset applied", $time, tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int pat[4];
        rst_n = 1'b0;
        drive_idle();

        do_reset("rst0");

        // Single master, responses two cycles after each grant
        cyc(1, 32'h100, 0, 0, 1, 0, 0, 0,  "t1.c1");
        cyc(1, 32'h104, 0, 0, 1, 0, 0, 0,  "t1.c2");
        cyc(1, 32'h108, 0, 0, 1, 1, 0, 0,  "t1.c3");
        cyc(0, 0,       0, 0, 0, 1, 0, -1, "t1.c4");
        cyc(0, 0,       0, 0, 0, 1, 0, -1, "t1.c5");

        // Contention with immediate responses
        do_reset("rst1");
`ifdef CVE2_IBUS_ARB_RR_EN
        pat = '{0, 1, 0, 1};
`else
        pat = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            cyc(1, 32'h200, 1, 32'h300, 1, (i > 0), 0, pat[i], "t2.cont");
        end
        cyc(0, 0, 0, 0, 0, 1, 0, -1, "t2.drain");

        // Lock: m1 waits for grant while m0 joins (m0 would win a fresh tie)
        cyc(0, 32'h200, 1, 32'h300, 0, 0, 0, 1, "t3.c1");
        cyc(1, 32'h200, 1, 32'h300, 0, 0, 0, 1, "t3.c2");
        cyc(1, 32'h200, 1, 32'h300, 0, 0, 0, 1, "t3.c3");
        cyc(1, 32'h200, 1, 32'h300, 1, 0, 0, 1, "t3.c4");
        cyc(1, 32'h200, 0, 0,       1, 0, 0, 0, "t3.c5");
        cyc(0, 0, 0, 0, 0, 1, 0, -1, "t3.r1");
        cyc(0, 0, 0, 0, 0, 1, 0, -1, "t3.r2");

        // Capacity gating at MaxOutstanding=2
        cyc(1, 32'h400, 0, 0,       1, 0, 0, 0,  "t4.c1");
        cyc(0, 0,       1, 32'h500, 1, 0, 0, 1,  "t4.c2");
        cyc(1, 32'h404, 0, 0,       1, 0, 0, -1, "t4.full");
        cyc(1, 32'h404, 0, 0,       1, 1, 0, 0,  "t4.swap");
        cyc(1, 32'h408, 0, 0,       1, 0, 0, -1, "t4.still_full");
        cyc(0, 0, 0, 0, 0, 1, 0, -1, "t4.r1");
        cyc(0, 0, 0, 0, 0, 1, 0, -1, "t4.r2");

        // Mixed ordering with error on the first response
        cyc(1, 32'h600, 0, 0,       1, 0, 0, 0, "t5.c1");
        cyc(0, 0,       1, 32'h700, 1, 0, 0, 1, "t5.c2");
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, -1, "t5.idle");
        end
        cyc(0, 0, 0, 0, 0, 1, 1, -1, "t5.r_m0");
        cyc(0, 0, 0, 0, 0, 1, 0, -1, "t5.r_m1");

        // Reset with two transactions outstanding
        cyc(1, 32'h900, 0, 0,       1, 0, 0, 0, "t6.c1");
        cyc(0, 0,       1, 32'h904, 1, 0, 0, 1, "t6.c2");
        do_reset("t6.rst");
        cyc(0, 0, 1, 32'h800, 1, 0, 0, 1,  "t6.after");
        cyc(0, 0, 0, 0,       0, 1, 0, -1, "t6.r1");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
